// File: rtl/axi4_mem_slave_rtl.sv
// axi4_mem_slave_rtl: AXI4 slave backed by a word-addressed register array.
// Independent write/read FSMs; optional LFSR throttling of the address/write readies.
module axi4_mem_slave_rtl #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int DEPTH = 1024,
  parameter int BP_EN = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [31:0] mem [DEPTH];
  logic [15:0] lfsr;
  logic live, gate;
  // live keeps the readies low until the first edge after reset release
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      lfsr <= LFSR_SEED;
      live <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      live <= 1'b1;
    end
  assign gate = live && (BP_EN == 0 || lfsr[0]);
  w_state_t w_state, w_next;
  logic [ID_WIDTH-1:0] aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0] aw_len, w_beat;
  logic aw_incr, aw_bad, w_dec, w_slv, aw_hs, w_hs, b_hs, w_oor, w_end;
  assign s_axi_awready = w_state == W_IDLE && gate;
  assign s_axi_wready = w_state == W_DATA && gate;
  assign s_axi_bvalid = w_state == W_RESP;
  assign s_axi_bid = aw_id;
  assign s_axi_bresp = s_axi_bvalid ? {w_dec | w_slv, w_dec} : 2'b00;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  assign b_hs = s_axi_bvalid && s_axi_bready;
  assign w_oor = |aw_addr[ADDR_WIDTH-1:AW+2];
  assign w_end = w_beat == aw_len;
  always_comb begin
    w_next = w_state;
    if (aw_hs) w_next = W_DATA;
    if (w_hs && w_end) w_next = W_RESP;
    if (b_hs) w_next = W_IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) w_state <= W_IDLE;
    else w_state <= w_next;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      aw_id <= '0;
      aw_addr <= '0;
      aw_len <= '0;
      aw_incr <= 1'b0;
      aw_bad <= 1'b0;
      w_beat <= '0;
      w_dec <= 1'b0;
      w_slv <= 1'b0;
    end else if (aw_hs) begin
      aw_id <= s_axi_awid;
      aw_addr <= s_axi_awaddr;
      aw_len <= s_axi_awlen;
      aw_incr <= s_axi_awburst == 2'b01;
      aw_bad <= s_axi_awburst[1] || s_axi_awsize != 3'b010;
      w_beat <= '0;
      w_dec <= 1'b0;
      w_slv <= 1'b0;
    end else if (w_hs) begin
      aw_addr <= aw_incr ? aw_addr + ADDR_WIDTH'(4) : aw_addr;
      w_beat <= w_beat + 8'd1;
      w_dec <= w_dec | w_oor;
      w_slv <= w_slv | aw_bad | (s_axi_wlast != w_end);
    end
  always_ff @(posedge aclk)
    if (w_hs && !aw_bad && !w_oor)
      for (int i = 0; i < 4; i++)
        if (s_axi_wstrb[i]) mem[aw_addr[AW+1:2]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
  r_state_t r_state, r_next;
  logic [ID_WIDTH-1:0] ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0] ar_len, r_beat;
  logic ar_incr, ar_bad, ar_hs, r_hs, r_oor;
  assign s_axi_arready = r_state == R_IDLE && gate;
  assign s_axi_rvalid = r_state == R_DATA;
  assign s_axi_rid = ar_id;
  assign s_axi_rlast = s_axi_rvalid && r_beat == ar_len;
  assign r_oor = |ar_addr[ADDR_WIDTH-1:AW+2];
  assign s_axi_rresp = !s_axi_rvalid ? 2'b00 : r_oor ? 2'b11 : ar_bad ? 2'b10 : 2'b00;
  // combinational read so a same-cycle write is seen only from the next cycle
  assign s_axi_rdata = s_axi_rvalid && !r_oor && !ar_bad ? mem[ar_addr[AW+1:2]] : 32'd0;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs = s_axi_rvalid && s_axi_rready;
  always_comb begin
    r_next = r_state;
    if (ar_hs) r_next = R_DATA;
    if (r_hs && s_axi_rlast) r_next = R_IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_state <= R_IDLE;
    else r_state <= r_next;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      ar_id <= '0;
      ar_addr <= '0;
      ar_len <= '0;
      ar_incr <= 1'b0;
      ar_bad <= 1'b0;
      r_beat <= '0;
    end else if (ar_hs) begin
      ar_id <= s_axi_arid;
      ar_addr <= s_axi_araddr;
      ar_len <= s_axi_arlen;
      ar_incr <= s_axi_arburst == 2'b01;
      ar_bad <= s_axi_arburst[1] || s_axi_arsize != 3'b010;
      r_beat <= '0;
    end else if (r_hs) begin
      ar_addr <= ar_incr ? ar_addr + ADDR_WIDTH'(4) : ar_addr;
      r_beat <= r_beat + 8'd1;
    end
endmodule
